uart_mmio: RTL and testbench

Synthesisable memory-mapped UART that replaces the behavioural UART stand-in at address 0x082 with real serial RX/TX logic. It has parametrised baud rate, FIFO depth and base address, RX/TX FIFOs, status flags and an RX interrupt. It sits on the CPU data bus beside the byte-lane memory and has the same one-cycle read latency as BRAM, so the CPU read path is unchanged.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_mmio_if.sv | 17 +
 rtl/uart_fifo.sv | 47 ++++
 rtl/uart_mmio.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: CPU address width, register map, STATUS bit positions
// and the state encoding used by both the TX and RX serial FSMs.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package uart_pkg;

  localparam int unsigned REG_DATA   = 0;
  localparam int unsigned REG_STATUS = 2;

  localparam int unsigned ST_RX_VALID   = 0;
  localparam int unsigned ST_TX_FULL    = 1;
  localparam int unsigned ST_RX_OVERRUN = 2;
  localparam int unsigned ST_TX_BUSY    = 3;
  localparam int unsigned ST_FRAME_ERR  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_mmio_if.sv
// CPU data-bus view of the UART: byte address, read/write strobes, write data,
// registered read data and the combinational address-decode hit.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

interface uart_mmio_if;
  logic [`ADDR_WIDTH-1:0] addr;
  logic                   rd;
  logic                   wr;
  logic [15:0]            wr_data;
  logic [15:0]            rd_data;
  logic                   sel;

  modport master (output addr, rd, wr, wr_data, input rd_data, sel);
  modport slave  (input addr, rd, wr, wr_data, output rd_data, sel);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty; a pop in
// the same cycle frees room for a push even when full.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty_c = (r_wr_ptr == r_rd_ptr);
  assign o_full_c  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_pop  = i_pop && !o_empty_c;
  assign w_do_push = i_push && (!o_full_c || w_do_pop);
  assign o_head_c  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: DATA at BASE_ADDR, STATUS at BASE_ADDR+2, one-cycle read latency.
// Optional build macro UART_LOOPBACK_EN feeds uart_tx back into the RX synchroniser.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ   = 27_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BASE_ADDR  = 'h082
) (
  input  logic              clk,
  input  logic              rst,
  uart_mmio_if.slave        bus,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              irq_rx
);

  localparam int unsigned    DIV      = CLOCK_HZ / BAUD;
  localparam int unsigned    CW       = $clog2(DIV);
  localparam logic [CW-1:0]  BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0]  HALF_END = CW'(DIV / 2 - 1);

  // Address decode
  logic w_hit_data, w_hit_stat;
  assign w_hit_data = (bus.addr == `ADDR_WIDTH'(BASE_ADDR + REG_DATA));
  assign w_hit_stat = (bus.addr == `ADDR_WIDTH'(BASE_ADDR + REG_STATUS));
  assign bus.sel    = w_hit_data || w_hit_stat;

  logic w_unused_wr_hi;
  assign w_unused_wr_hi = &{1'b0, bus.wr_data[15:8]};

  // FIFOs
  logic [7:0] w_tx_head, w_rx_head;
  logic       w_tx_full, w_tx_empty, w_tx_pop, w_tx_push;
  logic       w_rx_full, w_rx_empty, w_rx_pop, w_rx_push;
  logic [7:0] r_rx_shift;

  assign w_tx_push = bus.wr && w_hit_data;
  assign w_rx_pop  = bus.rd && w_hit_data;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .i_push(w_tx_push), .i_wdata(bus.wr_data[7:0]), .i_pop(w_tx_pop),
    .o_head_c(w_tx_head), .o_full_c(w_tx_full), .o_empty_c(w_tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .i_push(w_rx_push), .i_wdata(r_rx_shift), .i_pop(w_rx_pop),
    .o_head_c(w_rx_head), .o_full_c(w_rx_full), .o_empty_c(w_rx_empty)
  );

  // TX FSM
  uart_state_t   r_tx_state, w_tx_state_n;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
  logic [2:0]    r_tx_bit, w_tx_bit_n;
  logic [7:0]    r_tx_shift, w_tx_shift_n;
  logic          r_tx, w_tx_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx       <= w_tx_n;
    end
  end

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_tx_n       = r_tx;
    w_tx_pop     = 1'b0;
    case (r_tx_state)
      IDLE: begin
        w_tx_n = 1'b1;
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_shift_n = w_tx_head;
          w_tx_cnt_n   = '0;
          w_tx_n       = 1'b0;
          w_tx_state_n = START;
        end
      end
      START: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_cnt_n   = '0;
          w_tx_bit_n   = '0;
          w_tx_n       = r_tx_shift[0];
          w_tx_state_n = DATA;
        end else begin
          w_tx_cnt_n = r_tx_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_cnt_n = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_n       = 1'b1;
            w_tx_state_n = STOP;
          end else begin
            w_tx_bit_n   = r_tx_bit + 3'd1;
            w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
            w_tx_n       = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_n = r_tx_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_cnt_n = '0;
          // Chain straight into the next start bit to avoid an idle gap.
          if (!w_tx_empty) begin
            w_tx_pop     = 1'b1;
            w_tx_shift_n = w_tx_head;
            w_tx_n       = 1'b0;
            w_tx_state_n = START;
          end else begin
            w_tx_n       = 1'b1;
            w_tx_state_n = IDLE;
          end
        end else begin
          w_tx_cnt_n = r_tx_cnt + CW'(1);
        end
      end
      default: w_tx_state_n = IDLE;
    endcase
  end

  assign uart_tx = r_tx;

  // RX input select and synchroniser
  logic       w_rx_in;
  logic [1:0] r_rx_sync;
  logic       r_rx_prev;
  logic       w_rx_s, w_rx_fall;

`ifdef UART_LOOPBACK_EN
  logic w_unused_rx_pin;
  assign w_unused_rx_pin = uart_rx;
  assign w_rx_in         = r_tx;
`else
  assign w_rx_in = uart_rx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sync <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[0], w_rx_in};
      r_rx_prev <= r_rx_sync[1];
    end
  end

  assign w_rx_s    = r_rx_sync[1];
  assign w_rx_fall = r_rx_prev && !w_rx_s;

  // RX FSM
  uart_state_t   r_rx_state, w_rx_state_n;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
  logic [2:0]    r_rx_bit, w_rx_bit_n;
  logic [7:0]    w_rx_shift_n;
  logic          w_frame_err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
    end
  end

  always_comb begin
    w_rx_state_n    = r_rx_state;
    w_rx_cnt_n      = r_rx_cnt;
    w_rx_bit_n      = r_rx_bit;
    w_rx_shift_n    = r_rx_shift;
    w_rx_push       = 1'b0;
    w_frame_err_set = 1'b0;
    case (r_rx_state)
      IDLE: begin
        w_rx_cnt_n = '0;
        if (w_rx_fall) w_rx_state_n = START;
      end
      START: begin
        // Half-bit resample rejects short low glitches.
        if (r_rx_cnt == HALF_END) begin
          w_rx_cnt_n   = '0;
          w_rx_bit_n   = '0;
          w_rx_state_n = w_rx_s ? IDLE : DATA;
        end else begin
          w_rx_cnt_n = r_rx_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_rx_cnt == BIT_END) begin
          w_rx_cnt_n   = '0;
          w_rx_shift_n = {w_rx_s, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_n = STOP;
          else                  w_rx_bit_n   = r_rx_bit + 3'd1;
        end else begin
          w_rx_cnt_n = r_rx_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_rx_cnt == BIT_END) begin
          w_rx_cnt_n      = '0;
          w_rx_state_n    = IDLE;
          w_rx_push       = w_rx_s;
          w_frame_err_set = !w_rx_s;
        end else begin
          w_rx_cnt_n = r_rx_cnt + CW'(1);
        end
      end
      default: w_rx_state_n = IDLE;
    endcase
  end

  // Sticky flags: a new event in the same cycle wins over a CPU clear.
  logic r_rx_overrun, r_frame_err;
  logic w_overrun_set;
  assign w_overrun_set = w_rx_push && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_overrun <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_overrun_set) r_rx_overrun <= 1'b1;
      else if (bus.wr && w_hit_stat && bus.wr_data[ST_RX_OVERRUN]) r_rx_overrun <= 1'b0;
      if (w_frame_err_set) r_frame_err <= 1'b1;
      else if (bus.wr && w_hit_stat && bus.wr_data[ST_FRAME_ERR]) r_frame_err <= 1'b0;
    end
  end

  logic [15:0] w_status;
  always_comb begin
    w_status                = '0;
    w_status[ST_RX_VALID]   = !w_rx_empty;
    w_status[ST_TX_FULL]    = w_tx_full;
    w_status[ST_RX_OVERRUN] = r_rx_overrun;
    w_status[ST_TX_BUSY]    = (r_tx_state != IDLE) || !w_tx_empty;
    w_status[ST_FRAME_ERR]  = r_frame_err;
  end

  // Read data and interrupt
  logic [15:0] r_rd_data;
  logic        r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= !w_rx_empty;
      if (bus.rd && w_hit_data)      r_rd_data <= w_rx_empty ? 16'h0000 : {8'h00, w_rx_head};
      else if (bus.rd && w_hit_stat) r_rd_data <= w_status;
    end
  end

  assign bus.rd_data = r_rd_data;
  assign irq_rx      = r_irq;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at DIV=10: serial TX/RX framing, FIFOs, flags,
// glitch rejection and asynchronous reset, checked against a byte scoreboard.
module tb_uart_mmio;

  localparam int unsigned DIV    = 10;
  localparam logic [15:0] A_DATA = 16'h0082;
  localparam logic [15:0] A_STAT = 16'h0084;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic uart_tx;
  logic irq_rx;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  uart_mmio_if bus();

  uart_mmio #(
    .CLOCK_HZ(100_000), .BAUD(10_000), .FIFO_DEPTH(16), .BASE_ADDR('h082)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq_rx(irq_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.wr_data = d; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    for (int p = 0; p < 10; p++) begin
      uart_rx = (p == 0) ? 1'b0 : (p == 9) ? stop : b[p-1];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  // Finds the first start bit, then samples every bit period at mid-bit without resyncing.
  task automatic tx_check(input int nbytes, input bit chk_busy);
    logic        found;
    logic [7:0]  b;
    logic [15:0] st;
    logic        expb;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    check("tx_start_seen", {15'b0, found}, 16'h0001);
    for (int f = 0; f < nbytes; f++) begin
      b = tx_q.pop_front();
      for (int p = 0; p < 10; p++) begin
        if (chk_busy) begin
          bus_read(A_STAT, st);
          check($sformatf("tx_busy f%0d p%0d", f, p), st & 16'h0008, 16'h0008);
          repeat (3) @(negedge clk);
        end else begin
          repeat (5) @(negedge clk);
        end
        expb = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
        check($sformatf("tx_bit f%0d p%0d", f, p), {15'b0, uart_tx}, {15'b0, expb});
        repeat (5) @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  b;
    logic        found;

    rst = 1'b1; uart_rx = 1'b1;
    bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {15'b0, uart_tx}, 16'h0001);
    check("rst_rd_data", bus.rd_data, 16'h0000);
    check("rst_irq", {15'b0, irq_rx}, 16'h0000);
    rst = 1'b0;

    bus.addr = 16'h0082; #1;
    check("sel_data", {15'b0, bus.sel}, 16'h0001);
    bus.addr = 16'h0083; #1;
    check("sel_gap", {15'b0, bus.sel}, 16'h0000);
    bus.addr = 16'h0084; #1;
    check("sel_stat", {15'b0, bus.sel}, 16'h0001);
    bus_read(A_STAT, d);
    check("status_after_reset", d, 16'h0000);

    // Single byte, busy flag polled across the whole frame
    tx_q.push_back(8'h55);
    bus_write(A_DATA, 16'h0055);
    tx_check(1, 1'b1);
    bus_read(A_STAT, d);
    check("status_tx_done", d, 16'h0000);

    // Three queued bytes must stream with no idle gap
    tx_q.push_back(8'h41); tx_q.push_back(8'h42); tx_q.push_back(8'h43);
    fork
      begin
        bus_write(A_DATA, 16'h0041);
        bus_write(A_DATA, 16'h0042);
        bus_write(A_DATA, 16'h0043);
      end
      tx_check(3, 1'b0);
    join
    repeat (5) @(negedge clk);
    check("tx_idle_after_burst", {15'b0, uart_tx}, 16'h0001);

    // Single received frame
    rx_q.push_back(8'hA5);
    rx_send(8'hA5, 1'b1);
    check("irq_after_rx", {15'b0, irq_rx}, 16'h0001);
    bus_read(A_DATA, d);
    check("rx_data_a5", d, {8'h00, rx_q.pop_front()});
    repeat (2) @(negedge clk);
    check("irq_cleared", {15'b0, irq_rx}, 16'h0000);
    check("rd_data_hold", bus.rd_data, 16'h00A5);

    // Seventeen frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      b = 8'h30 + 8'(i);
      if (i < 16) rx_q.push_back(b);
      rx_send(b, 1'b1);
    end
    bus_read(A_STAT, d);
    check("status_overrun", d, 16'h0005);
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, d);
      check($sformatf("rx_fifo_%0d", i), d, {8'h00, rx_q.pop_front()});
    end
    bus_read(A_DATA, d);
    check("rx_empty_read", d, 16'h0000);
    bus_read(A_STAT, d);
    check("status_overrun_sticky", d, 16'h0004);
    bus_write(A_STAT, 16'h0004);
    bus_read(A_STAT, d);
    check("status_overrun_cleared", d, 16'h0000);

    // Framing error, then a short glitch
    rx_send(8'h12, 1'b0);
    bus_read(A_STAT, d);
    check("status_frame_err", d, 16'h0010);
    bus_read(A_DATA, d);
    check("frame_err_no_data", d, 16'h0000);
    bus_write(A_STAT, 16'h0010);
    bus_read(A_STAT, d);
    check("frame_err_cleared", d, 16'h0000);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(A_STAT, d);
    check("glitch_rejected", d, 16'h0000);
    check("glitch_no_irq", {15'b0, irq_rx}, 16'h0000);

    // Reset in the middle of data bit 4 of 0x0F
    bus_write(A_DATA, 16'h000F);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    check("rst_frame_start", {15'b0, found}, 16'h0001);
    repeat (55) @(negedge clk);
    check("tx_bit4_low", {15'b0, uart_tx}, 16'h0000);
    rst = 1'b1;
    #1;
    check("tx_async_reset", {15'b0, uart_tx}, 16'h0001);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, d);
    check("status_after_midframe_rst", d, 16'h0000);
    repeat (20) @(negedge clk);
    check("tx_idle_after_rst", {15'b0, uart_tx}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
